// File: rtl/mul_share_arbiter.sv
// ---------------------------------------------------------------------------
// mul_share_arbiter
//   Lets NREQ requesters share one pipelined 32x32->64 Multiplier.
//   Requests are issued round-robin. Results come back from the Multiplier
//   in issue order. An in-order tag FIFO records which requester owns each
//   in-flight op, so each result is routed back to the requester that issued
//   it. Both the issue path and the return path are combinational, so the
//   arbiter adds no latency.
//
//   Optional feature: define MUL_SHARE_ARB_PRIO_EN to give requester 0 strict
//   priority. The remaining requesters are then served round-robin.
//
// Ports
//   clock, reset_n          clock / asynchronous active-low reset
//   req_valid/ready         per-requester issue handshake
//   req_op1/op2             packed operands, requester i at [32i+31:32i]
//   resp_valid/ready        per-requester result handshake
//   resp_res                shared result bus (qualify with resp_valid)
//   flush                   abort all in-flight ops
//   mul_*                   Multiplier enq/deq/flush interface
//   inflight                tag FIFO occupancy
//   err                     sticky: Multiplier returned a result nobody owns
// ---------------------------------------------------------------------------
module mul_share_arbiter #(
    parameter int NREQ        = 4,
    parameter int OUTSTANDING = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ*32-1:0]             req_op1,
    input  logic [NREQ*32-1:0]             req_op2,
    output logic [NREQ-1:0]                resp_valid,
    input  logic [NREQ-1:0]                resp_ready,
    output logic [63:0]                    resp_res,
    input  logic                           flush,
    output logic                           mul_enq_valid,
    input  logic                           mul_enq_ready,
    output logic [31:0]                    mul_op1,
    output logic [31:0]                    mul_op2,
    input  logic                           mul_deq_valid,
    output logic                           mul_deq_ready,
    input  logic [63:0]                    mul_res,
    output logic                           mul_flush,
    output logic [$clog2(OUTSTANDING):0]   inflight,
    output logic                           err
);
    localparam int AW = $clog2(OUTSTANDING);
    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] r_rr_ptr;
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [PW-1:0] r_tags [OUTSTANDING];
    logic          r_err;

    logic [PW-1:0] w_grant;
    logic          w_any;
    logic [AW:0]   w_count;
    logic          w_empty;
    logic          w_full;
    logic          w_can_issue;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_head;

    // Circular first-valid search starting at r_rr_ptr.
    always_comb begin
        int v_idx;
        v_idx   = 0;
        w_grant = '0;
        w_any   = 1'b0;
`ifdef MUL_SHARE_ARB_PRIO_EN
        if (req_valid[0]) begin
            w_any = 1'b1;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                v_idx = int'(r_rr_ptr) + k;
                if (v_idx >= NREQ) v_idx = v_idx - NREQ;
                // requester 0 is excluded from the rotation
                if (!w_any && v_idx != 0 && req_valid[v_idx]) begin
                    w_any   = 1'b1;
                    w_grant = PW'(v_idx);
                end
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NREQ) v_idx = v_idx - NREQ;
            if (!w_any && req_valid[v_idx]) begin
                w_any   = 1'b1;
                w_grant = PW'(v_idx);
            end
        end
`endif
    end

    // The extra pointer bit separates full from empty when the indices match.
    assign w_count     = r_wptr - r_rptr;
    assign w_empty     = (r_wptr == r_rptr);
    // Full uses the registered count, so a pop in the same cycle does not
    // make room for a push until the next cycle.
    assign w_full      = (w_count == (AW+1)'(OUTSTANDING));
    assign w_can_issue = w_any & ~w_full & ~flush;
    assign w_push      = w_can_issue & mul_enq_ready;
    assign w_head      = r_tags[r_rptr[AW-1:0]];

    assign mul_enq_valid = w_can_issue;
    assign mul_op1       = w_any ? req_op1[{w_grant, 5'd0} +: 32] : '0;
    assign mul_op2       = w_any ? req_op2[{w_grant, 5'd0} +: 32] : '0;

    always_comb begin
        req_ready          = '0;
        req_ready[w_grant] = w_push;
    end

    // During a flush, stale Multiplier results are drained silently.
    always_comb begin
        resp_valid         = '0;
        resp_valid[w_head] = mul_deq_valid & ~w_empty & ~flush;
    end

    assign mul_deq_ready = flush | (~w_empty & resp_ready[w_head]);
    assign w_pop         = mul_deq_valid & mul_deq_ready & ~w_empty & ~flush;

    assign resp_res  = mul_res;
    assign mul_flush = flush;
    assign inflight  = w_count;
    assign err       = r_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_rr_ptr <= '0;
        end else if (flush) begin
            r_rptr <= r_wptr;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + (AW+1)'(1);
`ifdef MUL_SHARE_ARB_PRIO_EN
                if (w_grant != '0)
`endif
                    r_rr_ptr <= (w_grant == PW'(NREQ-1)) ? '0 : w_grant + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < OUTSTANDING; i++) r_tags[i] <= '0;
        end else if (w_push) begin
            r_tags[r_wptr[AW-1:0]] <= w_grant;
        end
    end

    // A result arriving with no owner means the Multiplier and the tag FIFO
    // have lost sync.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                                 r_err <= 1'b0;
        else if (mul_deq_valid & w_empty & ~flush)    r_err <= 1'b1;
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;
    localparam int NREQ = 4;
    localparam int OUTS = 4;
    localparam int LAT  = 2;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_op1 = '0;
    logic [NREQ*32-1:0] req_op2 = '0;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready = '1;
    logic [63:0]       resp_res;
    logic              flush = 1'b0;
    logic              mul_enq_valid;
    logic              mul_enq_ready;
    logic [31:0]       mul_op1, mul_op2;
    logic              mul_deq_valid;
    logic              mul_deq_ready;
    logic [63:0]       mul_res;
    logic              mul_flush;
    logic [2:0]        inflight;
    logic              err;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mul_share_arbiter #(.NREQ(NREQ), .OUTSTANDING(OUTS)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_res(resp_res),
        .flush(flush),
        .mul_enq_valid(mul_enq_valid), .mul_enq_ready(mul_enq_ready),
        .mul_op1(mul_op1), .mul_op2(mul_op2),
        .mul_deq_valid(mul_deq_valid), .mul_deq_ready(mul_deq_ready),
        .mul_res(mul_res), .mul_flush(mul_flush),
        .inflight(inflight), .err(err)
    );

    // ---------------- Multiplier model: in-order pipe, fixed latency ----------
    typedef struct { logic [63:0] r; int t; } ment_t;
    ment_t       mq[$];
    ment_t       me;
    int          cyc = 0;
    logic        m_dv = 1'b0;
    logic [63:0] m_res = '0;
    logic        m_room = 1'b1;
    logic        tb_enq_rdy = 1'b1;
    logic        force_dv = 1'b0;

    assign mul_enq_ready = tb_enq_rdy & m_room;
    assign mul_deq_valid = m_dv | force_dv;
    assign mul_res       = m_res;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_dv <= 1'b0; m_res <= '0; m_room <= 1'b1;
        end else begin
            cyc = cyc + 1;
            if (mul_flush) mq.delete();
            else begin
                if (m_dv && mul_deq_ready && mq.size() > 0) void'(mq.pop_front());
                if (mul_enq_valid && mul_enq_ready) begin
                    me.r = 64'(mul_op1) * 64'(mul_op2);
                    me.t = cyc;
                    mq.push_back(me);
                end
            end
            if (mq.size() > 0 && (cyc - mq[0].t) >= LAT - 1) begin
                m_dv <= 1'b1; m_res <= mq[0].r;
            end else begin
                m_dv <= 1'b0; m_res <= '0;
            end
            m_room <= (mq.size() < 6);
        end
    end

    // ---------------- Reference model of the arbiter ---------------------------
    int          exp_tags[$];
    logic [63:0] exp_res[$];
    int          exp_rr = 0;
    int          mg;
    logic        mpush;

    function automatic int exp_grant(input logic [NREQ-1:0] v);
        int r;
        int idx;
        r = -1;
`ifdef MUL_SHARE_ARB_PRIO_EN
        if (v[0]) return 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (exp_rr + k) % NREQ;
            if (r < 0 && idx != 0 && v[idx]) r = idx;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            idx = (exp_rr + k) % NREQ;
            if (r < 0 && v[idx]) r = idx;
        end
`endif
        return r;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exp_tags.delete(); exp_res.delete(); exp_rr = 0;
        end else if (flush) begin
            exp_tags.delete(); exp_res.delete();
        end else begin
            mg    = exp_grant(req_valid);
            mpush = (mg >= 0) && (exp_tags.size() < OUTS) && mul_enq_ready;
            if (exp_tags.size() > 0 && mul_deq_valid && resp_ready[exp_tags[0]]) begin
                void'(exp_tags.pop_front()); void'(exp_res.pop_front());
            end
            if (mpush) begin
                exp_tags.push_back(mg);
                exp_res.push_back(64'(req_op1[mg*32 +: 32]) * 64'(req_op2[mg*32 +: 32]));
`ifdef MUL_SHARE_ARB_PRIO_EN
                if (mg != 0) exp_rr = (mg + 1) % NREQ;
`else
                exp_rr = (mg + 1) % NREQ;
`endif
            end
        end
    end

    // expected combinational outputs for the current cycle
    logic [NREQ-1:0] e_rdy, e_rv;
    logic            e_enq, e_dr;
    logic [31:0]     e_op1, e_op2;
    int              e_infl;

    task automatic model_expect();
        int g;
        g      = exp_grant(req_valid);
        e_enq  = (g >= 0) && (exp_tags.size() < OUTS) && !flush;
        e_rdy  = (e_enq && mul_enq_ready) ? NREQ'(1 << g) : '0;
        e_op1  = (g >= 0) ? req_op1[g*32 +: 32] : '0;
        e_op2  = (g >= 0) ? req_op2[g*32 +: 32] : '0;
        if (flush) begin
            e_rv = '0; e_dr = 1'b1;
        end else if (exp_tags.size() > 0) begin
            e_rv = mul_deq_valid ? NREQ'(1 << exp_tags[0]) : '0;
            e_dr = resp_ready[exp_tags[0]];
        end else begin
            e_rv = '0; e_dr = 1'b0;
        end
        e_infl = exp_tags.size();
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic go_idle();
        req_valid = '0; flush = 1'b0; resp_ready = '1; tb_enq_rdy = 1'b1; force_dv = 1'b0;
    endtask

    task automatic reset_pulse();
        @(posedge clock); #1;
        go_idle();
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        go_idle();
        while (inflight != 0 && t < 40) begin @(negedge clock); t++; end
        n_chk++;
        if (inflight !== 3'd0) begin
            n_fail++; $display("FAIL drain_timeout inflight got=%0d req=0", inflight);
        end
    endtask

    // ---------------- Tests ----------------------------------------------------
    task automatic test_reset();
        go_idle();
        reset_n = 1'b0;
        @(negedge clock);
        n_chk++; if (req_ready !== 4'b0 || resp_valid !== 4'b0) begin
            n_fail++; $display("FAIL reset_hs got rdy=%b rv=%b req 0", req_ready, resp_valid); end
        n_chk++; if (mul_enq_valid !== 1'b0 || mul_deq_ready !== 1'b0 || mul_flush !== 1'b0) begin
            n_fail++; $display("FAIL reset_mul got enq=%b deq=%b fl=%b req 0", mul_enq_valid, mul_deq_ready, mul_flush); end
        n_chk++; if (inflight !== 3'd0 || err !== 1'b0) begin
            n_fail++; $display("FAIL reset_state got infl=%0d err=%b req 0", inflight, err); end
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single_op();
        int t;
        @(posedge clock); #1;
        req_valid = 4'b0100;
        req_op1[64 +: 32] = 32'h0000FFFF;
        req_op2[64 +: 32] = 32'h00010001;
        @(negedge clock);
        n_chk++; if (req_ready !== 4'b0100 || mul_op1 !== 32'h0000FFFF || mul_op2 !== 32'h00010001) begin
            n_fail++; $display("FAIL single_issue got rdy=%b op1=%h op2=%h", req_ready, mul_op1, mul_op2); end
        @(posedge clock); #1;
        req_valid = '0;
        t = 0;
        @(negedge clock);
        while (resp_valid == '0 && t < 20) begin @(negedge clock); t++; end
        n_chk++; if (resp_valid !== 4'b0100 || resp_res !== 64'h00000000FFFFFFFF) begin
            n_fail++; $display("FAIL single_resp got rv=%b res=%h req 0100 00000000ffffffff", resp_valid, resp_res); end
        @(negedge clock);
        n_chk++; if (inflight !== 3'd0) begin
            n_fail++; $display("FAIL single_inflight got=%0d req=0", inflight); end
    endtask

    task automatic test_round_robin();
        int          gr[$];
        int          rs[$];
        logic [63:0] rr[$];
        logic [63:0] prod [NREQ];
        int          t;
        reset_pulse();
        for (int i = 0; i < NREQ; i++) begin
            req_op1[i*32 +: 32] = $urandom();
            req_op2[i*32 +: 32] = $urandom();
            prod[i] = 64'(req_op1[i*32 +: 32]) * 64'(req_op2[i*32 +: 32]);
        end
        req_valid = '1;
        t = 0;
        while (rs.size() < 8 && t < 60) begin
            @(negedge clock);
            if (gr.size() < 8 && req_ready != '0) gr.push_back(onehot_idx(req_ready));
            if (resp_valid != '0) begin rs.push_back(onehot_idx(resp_valid)); rr.push_back(resp_res); end
            @(posedge clock); #1;
            if (gr.size() >= 8) req_valid = '0;
            t++;
        end
        n_chk++; if (rs.size() != 8 || gr.size() != 8) begin
            n_fail++; $display("FAIL rr_count got grants=%0d resps=%0d req 8", gr.size(), rs.size()); end
        for (int i = 0; i < 8 && i < gr.size() && i < rs.size(); i++) begin
`ifndef MUL_SHARE_ARB_PRIO_EN
            n_chk++; if (gr[i] != i % NREQ) begin
                n_fail++; $display("FAIL rr_grant[%0d] got=%0d req=%0d", i, gr[i], i % NREQ); end
`endif
            n_chk++; if (rs[i] != gr[i]) begin
                n_fail++; $display("FAIL rr_route[%0d] got=%0d req=%0d", i, rs[i], gr[i]); end
            n_chk++; if (gr[i] >= 0 && rr[i] !== prod[gr[i]]) begin
                n_fail++; $display("FAIL rr_res[%0d] got=%h req=%h", i, rr[i], prod[gr[i]]); end
        end
        drain();
    endtask

    task automatic test_full();
        int grants;
        int t;
        @(posedge clock); #1;
        resp_ready = '0; req_valid = 4'b0001; req_op1[31:0] = $urandom(); req_op2[31:0] = $urandom();
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (req_ready[0]) grants++;
            if (grants == 4) break;
            @(posedge clock); #1;
            req_op1[31:0] = $urandom();
        end
        @(posedge clock); #1;
        @(negedge clock);
        n_chk++; if (inflight !== 3'd4 || req_ready !== 4'b0 || mul_enq_valid !== 1'b0) begin
            n_fail++; $display("FAIL full_block got infl=%0d rdy=%b enq=%b req 4 0000 0", inflight, req_ready, mul_enq_valid); end
        t = 0;
        while (resp_valid == '0 && t < 10) begin @(negedge clock); t++; end
        n_chk++; if (resp_valid !== 4'b0001) begin
            n_fail++; $display("FAIL full_head got rv=%b req 0001", resp_valid); end
        @(posedge clock); #1;
        resp_ready = 4'b0001;
        @(negedge clock);
        n_chk++; if (mul_enq_valid !== 1'b0 || mul_deq_ready !== 1'b1) begin
            n_fail++; $display("FAIL full_samecycle got enq=%b deq=%b req 0 1", mul_enq_valid, mul_deq_ready); end
        @(posedge clock); #1;
        resp_ready = '0;
        @(negedge clock);
        n_chk++; if (inflight !== 3'd3 || mul_enq_valid !== 1'b1 || req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL full_resume got infl=%0d enq=%b rdy=%b req 3 1 0001", inflight, mul_enq_valid, req_ready); end
        drain();
    endtask

    task automatic test_hol();
        logic [63:0] py;
        logic        saw2;
        int          t;
        @(posedge clock); #1;
        resp_ready = 4'b1101;
        req_valid  = 4'b0010; req_op1[32 +: 32] = $urandom(); req_op2[32 +: 32] = $urandom();
        @(negedge clock);
        n_chk++; if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL hol_issue1 got=%b req 0010", req_ready); end
        @(posedge clock); #1;
        req_valid = 4'b0100; req_op1[64 +: 32] = $urandom(); req_op2[64 +: 32] = $urandom();
        py = 64'(req_op1[64 +: 32]) * 64'(req_op2[64 +: 32]);
        @(negedge clock);
        n_chk++; if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL hol_issue2 got=%b req 0100", req_ready); end
        @(posedge clock); #1;
        req_valid = '0;
        saw2 = 1'b0;
        for (int c = 0; c < 6; c++) begin @(negedge clock); if (resp_valid[2]) saw2 = 1'b1; end
        n_chk++; if (saw2 !== 1'b0 || resp_valid !== 4'b0010 || inflight !== 3'd2) begin
            n_fail++; $display("FAIL hol_block got saw2=%b rv=%b infl=%0d req 0 0010 2", saw2, resp_valid, inflight); end
        @(posedge clock); #1;
        resp_ready = '1;
        t = 0;
        @(negedge clock);
        while (!resp_valid[2] && t < 10) begin @(negedge clock); t++; end
        n_chk++; if (resp_valid !== 4'b0100 || resp_res !== py) begin
            n_fail++; $display("FAIL hol_release got rv=%b res=%h req 0100 %h", resp_valid, resp_res, py); end
        drain();
    endtask

    task automatic test_flush();
        int   grants;
        logic seen;
        @(posedge clock); #1;
        resp_ready = '0; req_valid = 4'b1011;
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (req_ready != '0) grants++;
            if (grants == 3) break;
            @(posedge clock); #1;
        end
        @(posedge clock); #1;
        flush = 1'b1; req_valid = 4'b0001;
        @(negedge clock);
        n_chk++; if (inflight !== 3'd3 || mul_flush !== 1'b1 || mul_enq_valid !== 1'b0 || req_ready !== 4'b0) begin
            n_fail++; $display("FAIL flush_cycle got infl=%0d fl=%b enq=%b rdy=%b req 3 1 0 0000", inflight, mul_flush, mul_enq_valid, req_ready); end
        n_chk++; if (resp_valid !== 4'b0 || mul_deq_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_drain got rv=%b deq=%b req 0000 1", resp_valid, mul_deq_ready); end
        @(posedge clock); #1;
        go_idle();
        @(negedge clock);
        n_chk++; if (inflight !== 3'd0) begin
            n_fail++; $display("FAIL flush_inflight got=%0d req=0", inflight); end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin @(negedge clock); if (resp_valid != '0) seen = 1'b1; end
        n_chk++; if (seen !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL flush_after got seen=%b err=%b req 0 0", seen, err); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(posedge clock); #1;
            req_valid  = NREQ'($urandom());
            resp_ready = NREQ'($urandom() | $urandom());
            tb_enq_rdy = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < NREQ; i++) begin
                req_op1[i*32 +: 32] = $urandom();
                req_op2[i*32 +: 32] = $urandom();
            end
            @(negedge clock);
            model_expect();
            n_chk++; if (req_ready !== e_rdy || mul_enq_valid !== e_enq) begin
                n_fail++; $display("FAIL rnd_issue c=%0d got rdy=%b enq=%b req %b %b", c, req_ready, mul_enq_valid, e_rdy, e_enq); end
            n_chk++; if (mul_op1 !== e_op1 || mul_op2 !== e_op2) begin
                n_fail++; $display("FAIL rnd_ops c=%0d got %h %h req %h %h", c, mul_op1, mul_op2, e_op1, e_op2); end
            n_chk++; if (resp_valid !== e_rv || mul_deq_ready !== e_dr) begin
                n_fail++; $display("FAIL rnd_resp c=%0d got rv=%b dr=%b req %b %b", c, resp_valid, mul_deq_ready, e_rv, e_dr); end
            if (e_rv != '0) begin
                n_chk++; if (resp_res !== exp_res[0]) begin
                    n_fail++; $display("FAIL rnd_res c=%0d got %h req %h", c, resp_res, exp_res[0]); end
            end
            n_chk++; if (int'(inflight) != e_infl || err !== 1'b0) begin
                n_fail++; $display("FAIL rnd_state c=%0d got infl=%0d err=%b req %0d 0", c, inflight, err, e_infl); end
        end
        drain();
    endtask

    task automatic test_err();
        @(posedge clock); #1;
        force_dv = 1'b1;
        @(posedge clock); #1;
        force_dv = 1'b0;
        @(negedge clock);
        n_chk++; if (err !== 1'b1) begin
            n_fail++; $display("FAIL err_set got=%b req=1", err); end
        repeat (3) @(negedge clock);
        n_chk++; if (err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky got=%b req=1", err); end
        reset_pulse();
        @(negedge clock);
        n_chk++; if (err !== 1'b0) begin
            n_fail++; $display("FAIL err_reset got=%b req=0", err); end
    endtask

`ifdef MUL_SHARE_ARB_PRIO_EN
    task automatic test_prio();
        logic bad;
        @(posedge clock); #1;
        req_valid = 4'b1001;
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (req_ready[3] || (mul_enq_valid && !req_ready[0])) bad = 1'b1;
        end
        n_chk++; if (bad !== 1'b0) begin
            n_fail++; $display("FAIL prio_grant got bad=%b req 0", bad); end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_full();
        test_hol();
        test_flush();
`ifdef MUL_SHARE_ARB_PRIO_EN
        test_prio();
`endif
        test_random();
        test_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one Multiplier instance (32x32 -> 64, enq/deq valid-ready handshake, in-order results) between NREQ requesters.
- Round-robin issue arbitration; an in-order tag FIFO records which requester owns each in-flight op, and results are routed back to that requester.
- Sits between the client ports (core lanes, logic-analyzer test port) and the Multiplier inside the user wrapper.

Parameters:
- NREQ, 4, number of requesters (2..8).
- OUTSTANDING, 4, max in-flight ops; tag FIFO depth (power of 2, >=2).

Ports:
- clock  input  1  single clock for all logic.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester op valid.
- req_ready  output  NREQ  per-requester op accepted.
- req_op1  input  NREQ*32  operand 1, requester i at [32i+31:32i].
- req_op2  input  NREQ*32  operand 2, same packing.
- resp_valid  output  NREQ  result valid for requester i.
- resp_ready  input  NREQ  requester i accepts result.
- resp_res  output  64  result, shared by all requesters (qualify with resp_valid).
- flush  input  1  abort all in-flight ops.
- mul_enq_valid  output  1  to Multiplier io_enq_valid.
- mul_enq_ready  input  1  from Multiplier io_enq_ready.
- mul_op1  output  32  to Multiplier io_op1.
- mul_op2  output  32  to Multiplier io_op2.
- mul_deq_valid  input  1  from Multiplier io_deq_valid.
- mul_deq_ready  output  1  to Multiplier io_deq_ready.
- mul_res  input  64  from Multiplier io_res.
- mul_flush  output  1  to Multiplier io_flush.
- inflight  output  $clog2(OUTSTANDING)+1  current tag FIFO occupancy.
- err  output  1  sticky protocol error.

Behaviour:
- Reset (reset_n low, async):
  - rr_ptr=0; tag FIFO empty; inflight=0; err=0; mul_flush=0.
  - All outputs derived from state are 0: req_ready, resp_valid, mul_enq_valid, mul_deq_ready.
- Grant, combinational:
  - g = first i with req_valid[i], searching circularly from rr_ptr.
  - can_issue = |req_valid & ~full & ~flush.
  - mul_enq_valid = can_issue; mul_op1/op2 = operands of requester g (0 when nothing is valid).
  - req_ready[g] = can_issue & mul_enq_ready; all other req_ready bits are 0.
- Issue fire (mul_enq_valid & mul_enq_ready):
  - push g into the tag FIFO.
  - rr_ptr <= (g+1) mod NREQ.
  - If no fire, rr_ptr holds.
- Full:
  - full = (inflight==OUTSTANDING).
  - A same-cycle pop does not unblock a push; issue resumes the cycle after inflight drops.
- Response path:
  - h = FIFO head tag.
  - resp_valid[h] = mul_deq_valid & ~empty; all other resp_valid bits are 0.
  - mul_deq_ready = ~empty & resp_ready[h].
  - resp_res = mul_res (combinational passthrough).
  - Dequeue fire pops the FIFO.
- inflight: +1 on push, -1 on pop, unchanged on simultaneous push+pop.
- Zero added latency: the request->Multiplier and Multiplier->response paths are combinational. Total latency equals the Multiplier latency.
- Backpressure:
  - A stalled head requester (resp_ready low) blocks all later results; in-order delivery is required.
  - Other requesters may still issue until the FIFO is full.
- Flush:
  - flush high -> mul_flush=1 the same cycle; tag FIFO cleared at the next edge; inflight=0; no issue that cycle.
  - rr_ptr is unchanged.
  - While flush is high, resp_valid=0 and mul_deq_ready=1, so stale results are drained.
- Error:
  - err is set when mul_deq_valid=1 while the FIFO is empty and flush=0.
  - err clears only on reset.
- Wrap-around: FIFO pointers are $clog2(OUTSTANDING)+1 bits; the extra bit distinguishes full from empty.

Optional Feature:
- MUL_SHARE_ARB_PRIO_EN defined:
  - Requester 0 has strict priority; g=0 whenever req_valid[0].
  - Otherwise round-robin over 1..NREQ-1.
  - rr_ptr is updated only on grants to requesters 1..NREQ-1.
- Undefined: pure round-robin over all NREQ requesters as above.

Test Plan:
- Single op:
  - Stimulus: req_valid=4'b0100, op1=0x0000FFFF, op2=0x00010001, Multiplier ready.
  - Response: req_ready=4'b0100; later resp_valid=4'b0100 with resp_res=0x00000000FFFFFFFF; inflight returns 0.
- Round-robin fairness:
  - Stimulus: all 4 requesters valid continuously, rr_ptr=0 after reset.
  - Response: grants in order 0,1,2,3,0; each result is returned to its issuer in the same order.
- Full:
  - Stimulus: hold resp_ready=0; issue 4 ops.
  - Response: inflight=4; req_ready=0 and mul_enq_valid=0 on the 5th request. Raising resp_ready pops one; issue resumes the next cycle.
- Head-of-line blocking:
  - Stimulus: requester 1 issues, then requester 2 issues; resp_ready[1]=0.
  - Response: resp_valid[2] stays 0 until requester 1 accepts its result.
- Flush:
  - Stimulus: 3 ops in flight, pulse flush for one cycle.
  - Response: mul_flush=1 that cycle, inflight=0 next cycle, no resp_valid for the flushed ops, err=0.
- Protocol error / priority:
  - Stimulus: force mul_deq_valid=1 with the FIFO empty.
  - Response: err=1, and it stays set until reset_n is asserted.
  - With MUL_SHARE_ARB_PRIO_EN defined: requesters 0 and 3 both valid -> requester 0 is granted every cycle.
